// File: rtl/jedro_1_sig_pkg.sv
// Shared types and constants for the signature-dump monitor.
package jedro_1_sig_pkg;

  typedef enum logic [2:0] {RUN, CHECK, READ, WAIT, SEND, DONE} sig_state_e;

  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  function automatic int word_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int byte_addr_w(input int mem_words, input int data_w);
    return $clog2(mem_words * (data_w / 8));
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/jedro_1_sig_crc32.sv
// Combinational next-state of a reflected CRC-32 over one word, LSB byte first.
module jedro_1_sig_crc32
  import jedro_1_sig_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [31:0]           crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      c = c ^ {24'h0, data_i[8*b +: 8]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/jedro_1_sig_dumper.sv
// Signature-dump monitor: snoops halt/start/end cells, then streams the region out.
// Define SIG_CRC_EN to compute a CRC-32 over the emitted words on crc_o.
module jedro_1_sig_dumper
  import jedro_1_sig_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_SIZE_WORDS = 1 << 19,
  parameter int TIMEOUT        = 1000000,
  parameter int CNT_WIDTH      = 32,
  parameter int SIG_START_CELL = MEM_SIZE_WORDS - 1,
  parameter int SIG_END_CELL   = MEM_SIZE_WORDS - 2,
  parameter int HALT_CELL      = MEM_SIZE_WORDS - 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    bus_stb_i,
  input  logic [DATA_WIDTH/8-1:0] bus_we_i,
  input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
  input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
  input  logic                    bus_ack_i,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i,
  output logic                    sig_valid_o,
  output logic [DATA_WIDTH-1:0]   sig_data_o,
  output logic                    sig_last_o,
  input  logic                    sig_ready_i,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
  output logic [31:0]             crc_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = word_shift(DATA_WIDTH);
  localparam int BAW   = byte_addr_w(MEM_SIZE_WORDS, DATA_WIDTH);
  localparam logic [BAW-1:0] ALIGN_MASK = BAW'(BYTES - 1);
  localparam logic [BAW:0]   STEP       = (BAW + 1)'(BYTES);

  sig_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] start_sh, end_sh, halt_sh, data_q;
  logic [BAW-1:0]        widx, start_a, end_a, ptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  tmo_q, err_q;
  logic                  commit, halt, tmo_hit, bad, last;
  logic                  load_ptr, inc_ptr, cap_data, fire, set_tmo, set_err;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [BYTES-1:0]      we);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < BYTES; b++)
      if (we[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  assign widx    = bus_addr_i[BAW-1:0] >> SHIFT;
  assign commit  = (state_q == RUN) & bus_stb_i & (|bus_we_i) & bus_ack_i;
  assign start_a = start_sh[BAW-1:0];
  assign end_a   = end_sh[BAW-1:0];
  assign halt    = (halt_sh == DATA_WIDTH'(1));
  assign tmo_hit = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
  assign bad     = (|(start_a & ALIGN_MASK)) | (|(end_a & ALIGN_MASK)) | (start_a > end_a);
  assign last    = (({1'b0, ptr_q} + STEP) >= {1'b0, end_a});

  // Snoop stage: shadow cells only track writes while the program runs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      start_sh <= '0;
      end_sh   <= '0;
      halt_sh  <= '0;
    end else if (commit) begin
      if (widx == BAW'(SIG_START_CELL)) start_sh <= merge_bytes(start_sh, bus_wdata_i, bus_we_i);
      if (widx == BAW'(SIG_END_CELL))   end_sh   <= merge_bytes(end_sh, bus_wdata_i, bus_we_i);
      if (widx == BAW'(HALT_CELL))      halt_sh  <= merge_bytes(halt_sh, bus_wdata_i, bus_we_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_ptr = 1'b0;
    inc_ptr  = 1'b0;
    cap_data = 1'b0;
    fire     = 1'b0;
    set_tmo  = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = CHECK;
        end else if (tmo_hit) begin
          state_d = CHECK;
          set_tmo = 1'b1;
        end
      end
      CHECK: begin
        if (bad) begin
          state_d = DONE;
          set_err = 1'b1;
        end else if (start_a == end_a) begin
          state_d = DONE;
        end else begin
          state_d  = READ;
          load_ptr = 1'b1;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d  = SEND;
          cap_data = 1'b1;
        end
      end
      SEND: begin
        if (sig_ready_i) begin
          fire = 1'b1;
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            inc_ptr = 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // Dump stage: counter, sticky flags, region pointer and the held word
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
      data_q <= '0;
    end else begin
      if (state_q == RUN && state_d == RUN) cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (set_tmo) tmo_q <= 1'b1;
      if (set_err) err_q <= 1'b1;
      if (load_ptr)     ptr_q <= start_a;
      else if (inc_ptr) ptr_q <= ptr_q + BAW'(BYTES);
      if (cap_data) data_q <= mem_rdata_i;
    end
  end

  assign mem_req_o   = (state_q == READ);
  assign mem_addr_o  = ADDR_WIDTH'(ptr_q >> SHIFT);
  assign sig_valid_o = (state_q == SEND);
  assign sig_data_o  = data_q;
  assign sig_last_o  = (state_q == SEND) & last;
  assign done_o      = (state_q == DONE);
  assign timeout_o   = tmo_q;
  assign err_o       = err_q;
  assign cycle_cnt_o = cnt_q;

  logic unused_hi;
  assign unused_hi = ^{bus_addr_i[ADDR_WIDTH-1:BAW], start_sh[DATA_WIDTH-1:BAW], end_sh[DATA_WIDTH-1:BAW]};

`ifdef SIG_CRC_EN
  logic [31:0] crc_q, crc_nxt;

  jedro_1_sig_crc32 #(.DATA_WIDTH(DATA_WIDTH)) u_crc (
    .crc_i  (crc_q),
    .data_i (data_q),
    .crc_o  (crc_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i)   crc_q <= CRC32_INIT;
    else if (fire) crc_q <= crc_nxt;
  end

  assign crc_o = crc_q ^ CRC32_XOROUT;
`else
  logic unused_fire;
  assign unused_fire = fire;
  assign crc_o       = '0;
`endif

endmodule

// File: tb/tb_jedro_1_sig_dumper.sv
// Directed-plus-random bench for jedro_1_sig_dumper with a behavioural region model.
module tb_jedro_1_sig_dumper;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MW  = 1024;
  localparam int TMO = 50;
  localparam int CW  = 16;
  localparam logic [31:0] START_OFF = 32'hFFC;
  localparam logic [31:0] END_OFF   = 32'hFF8;
  localparam logic [31:0] HALT_OFF  = 32'hFF4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          bus_stb = 1'b0;
  logic [3:0]    bus_we = 4'h0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_ack = 1'b0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          sig_valid;
  logic [31:0]   sig_data;
  logic          sig_last;
  logic          sig_ready = 1'b0;
  logic          done, tmo, err;
  logic [CW-1:0] cyc_cnt;
  logic [31:0]   crc;

  jedro_1_sig_dumper #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE_WORDS(MW), .TIMEOUT(TMO), .CNT_WIDTH(CW),
    .SIG_START_CELL(MW - 1), .SIG_END_CELL(MW - 2), .HALT_CELL(MW - 3)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .bus_stb_i(bus_stb), .bus_we_i(bus_we), .bus_addr_i(bus_addr),
    .bus_wdata_i(bus_wdata), .bus_ack_i(bus_ack),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
    .sig_valid_o(sig_valid), .sig_data_o(sig_data), .sig_last_o(sig_last), .sig_ready_i(sig_ready),
    .done_o(done), .timeout_o(tmo), .err_o(err), .cycle_cnt_o(cyc_cnt), .crc_o(crc)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint r_edge = 0;
  int     rmode = 0;
  int     req_cnt = 0;
  int     valid_cnt = 0;
  int     stab_err = 0;
  logic [31:0] mem_words [MW];
  logic [31:0] rx_data[$];
  logic        rx_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory read port: 1..3 cycles latency, garbage on rdata when not valid
  logic        pend = 1'b0;
  int          lat = 0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_words[pend_addr[9:0]];
          pend       = 1'b0;
        end else begin
          lat--;
        end
      end
      if (mem_req) begin
        req_cnt++;
        pend      = 1'b1;
        lat       = $urandom_range(0, 2);
        pend_addr = mem_addr;
      end
    end
  end

  // Stream sink: ready policy per rmode, records handshakes, watches stability
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;
  int          bp = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      sig_ready = 1'b0;
      hold      = 1'b0;
      bp        = 0;
    end else begin
      if (hold && !(sig_valid && sig_data == hold_data && sig_last == hold_last)) stab_err++;
      case (rmode)
        0: sig_ready = 1'b1;
        1: sig_ready = 1'($urandom_range(0, 1));
        2: begin
          if (sig_valid && bp >= 5) begin
            sig_ready = 1'b1;
            bp = 0;
          end else begin
            sig_ready = 1'b0;
            if (sig_valid) bp++;
          end
        end
        default: sig_ready = 1'b0;
      endcase
      hold = 1'b0;
      if (sig_valid) begin
        valid_cnt++;
        if (sig_ready) begin
          rx_data.push_back(sig_data);
          rx_last.push_back(sig_last);
        end else begin
          hold      = 1'b1;
          hold_data = sig_data;
          hold_last = sig_last;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 built from the MSB-first form with reflected bytes and result
  function automatic logic [31:0] crc_ref(input int first, input int n);
    logic [31:0] c, w, r;
    logic [7:0]  by, br;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = mem_words[first + i];
      for (int b = 0; b < 4; b++) begin
        by = w[8*b +: 8];
        for (int k = 0; k < 8; k++) br[k] = by[7-k];
        c = c ^ {br, 24'h0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return r ^ 32'hFFFF_FFFF;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "/valid"}, sig_valid, 0);
    chk({tag, "/last"}, sig_last, 0);
    chk({tag, "/data"}, sig_data, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/timeout"}, tmo, 0);
    chk({tag, "/err"}, err, 0);
    chk({tag, "/cnt"}, cyc_cnt, 0);
    chk({tag, "/req"}, mem_req, 0);
    chk({tag, "/addr"}, mem_addr, 0);
    chk({tag, "/crc"}, crc, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus_stb = 1'b0; bus_we = 4'h0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    rx_data.delete();
    rx_last.delete();
    req_cnt = 0; valid_cnt = 0; stab_err = 0;
    rstn   = 1'b1;
    r_edge = cyc + 1;
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data, input logic [3:0] we,
                           input int pre, output longint c_edge);
    bus_addr  = (32'($urandom) & 32'hFFFF_F000) | off;
    bus_wdata = data;
    bus_we    = we;
    bus_stb   = 1'b1;
    bus_ack   = 1'b0;
    repeat (pre) @(negedge clk);
    bus_ack = 1'b1;
    c_edge  = cyc + 1;
    @(negedge clk);
    bus_stb = 1'b0; bus_ack = 1'b0; bus_we = 4'h0;
  endtask

  // hmode: 0 halt early, 1 no halt, 2 halt seen on the last RUN cycle, 3 one cycle late, 4 lane merge first
  task automatic scenario(input string tag, input logic [31:0] s, input logic [31:0] e,
                          input int hmode, input int rm);
    longint c_edge, run_len, exp_cnt;
    logic [31:0] sm, em, exp_crc;
    logic bad_r, exp_to;
    int words, first, lasts;
    do_reset();
    rmode = rm;
    bus_write(START_OFF, s, 4'hF, $urandom_range(0, 2), c_edge);
    bus_write(END_OFF, e, 4'hF, $urandom_range(0, 2), c_edge);
    run_len = 1000;
    case (hmode)
      0: begin
        bus_write(HALT_OFF, 32'h1, 4'hF, $urandom_range(0, 2), c_edge);
        run_len = c_edge - r_edge + 1;
      end
      2, 3: begin
        while ((cyc + 1) - r_edge + 1 < longint'(TMO - 3 + hmode)) @(negedge clk);
        bus_write(HALT_OFF, 32'h1, 4'hF, 0, c_edge);
        run_len = c_edge - r_edge + 1;
      end
      4: begin
        bus_write(HALT_OFF, 32'hFFFF_FF00, 4'hF, $urandom_range(0, 2), c_edge);
        bus_write(HALT_OFF, 32'h0000_0001, 4'b0001, $urandom_range(0, 2), c_edge);
        repeat (4) @(negedge clk);
        chk({tag, "/merge_no_halt"}, done, 0);
        chk({tag, "/merge_run_cnt"}, cyc_cnt, 64'(cyc - r_edge + 1));
        bus_write(HALT_OFF, 32'h1, 4'hF, $urandom_range(0, 2), c_edge);
        run_len = c_edge - r_edge + 1;
      end
      default: ;
    endcase
    for (int i = 0; i < 600 && !done; i++) @(negedge clk);
    repeat (2) @(negedge clk);

    exp_to  = (run_len > TMO - 1);
    exp_cnt = exp_to ? longint'(TMO - 1) : run_len;
    sm      = s & 32'hFFF;
    em      = e & 32'hFFF;
    bad_r   = (sm[1:0] != 2'b00) || (em[1:0] != 2'b00) || (sm > em);
    words   = bad_r ? 0 : int'((em - sm) >> 2);
    first   = int'(sm >> 2);
`ifdef SIG_CRC_EN
    exp_crc = crc_ref(first, words);
`else
    exp_crc = 32'h0;
`endif

    chk({tag, "/done"}, done, 1);
    chk({tag, "/timeout"}, tmo, exp_to);
    chk({tag, "/err"}, err, bad_r);
    chk({tag, "/cycle_cnt"}, cyc_cnt, 64'(exp_cnt));
    chk({tag, "/nwords"}, rx_data.size(), words);
    chk({tag, "/nreq"}, req_cnt, words);
    chk({tag, "/valid_seen"}, valid_cnt != 0, words != 0);
    chk({tag, "/stable"}, stab_err, 0);
    chk({tag, "/crc"}, crc, exp_crc);
    lasts = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_last[i]) lasts++;
      if (i < words) begin
        chk($sformatf("%s/data%0d", tag, i), rx_data[i], mem_words[first + i]);
        chk($sformatf("%s/last%0d", tag, i), rx_last[i], i == words - 1);
      end
    end
    chk({tag, "/last_count"}, lasts, words != 0);
  endtask

  initial begin
    logic [31:0] s, e;
    int sw, n;
    longint c_edge;
    for (int i = 0; i < MW; i++) mem_words[i] = $urandom;

    repeat (3) @(negedge clk);
    chk_zero("reset");

    scenario("normal", 32'h100, 32'h10C, 0, 0);
    scenario("backpressure", 32'h100, 32'h10C, 0, 2);
    scenario("timeout", 32'h200, 32'h204, 1, 0);
    scenario("halt_at_boundary", 32'h180, 32'h188, 2, 1);
    scenario("halt_too_late", 32'h1C0, 32'h1C4, 3, 0);
    scenario("bad_order", 32'h110, 32'h100, 0, 0);
    scenario("bad_start_align", 32'h102, 32'h10C, 0, 0);
    scenario("bad_end_align", 32'h100, 32'h10E, 0, 0);
    scenario("empty", 32'h120, 32'h120, 0, 0);
    scenario("lane_merge", 32'h240, 32'h24C, 4, 1);

    mem_words[32'h50] = 32'h0;
    scenario("crc_zero", 32'h140, 32'h144, 0, 0);
`ifdef SIG_CRC_EN
    chk("crc_zero_const", crc, 32'h2144_DF1C);
`endif

    for (int k = 0; k < 6; k++) begin
      sw = $urandom_range(0, 900);
      n  = $urandom_range(1, 6);
      s  = 32'(sw * 4) | (32'($urandom) & 32'hFFFF_F000);
      e  = 32'((sw + n) * 4) | (32'($urandom) & 32'hFFFF_F000);
      scenario($sformatf("random%0d", k), s, e, 0, 1);
    end

    // Reset while a word is on the stream and the sink is stalled
    do_reset();
    rmode = 3;
    bus_write(START_OFF, 32'h300, 4'hF, 0, c_edge);
    bus_write(END_OFF, 32'h30C, 4'hF, 0, c_edge);
    bus_write(HALT_OFF, 32'h1, 4'hF, 0, c_edge);
    for (int i = 0; i < 200 && !sig_valid; i++) @(negedge clk);
    chk("midsend/valid_before", sig_valid, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("midsend");
    scenario("after_reset", 32'h300, 32'h30C, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jedro_1_sig_dumper.md
Name: jedro_1_sig_dumper

Overview:
Synthesizable signature-dump monitor for riscof compliance runs on FPGA or in simulation without hierarchical memory peeking. Snoops the core's data-bus writes to three control cells: halt, signature start and signature end. On halt or timeout, it walks the signature region through a dedicated memory read port. Signature words go out on a valid/ready stream for a UART or file sink.

Parameters:
DATA_WIDTH, 32, bus and signature word width (multiple of 8)
ADDR_WIDTH, 32, bus address width
MEM_SIZE_WORDS, 1<<19, memory depth; addresses are masked to $clog2(MEM_SIZE_WORDS*DATA_WIDTH/8) bits
TIMEOUT, 1000000, run cycles before a forced dump
CNT_WIDTH, 32, cycle-counter width; must satisfy TIMEOUT < 2**CNT_WIDTH
SIG_START_CELL, MEM_SIZE_WORDS-1, word index of the start-address cell
SIG_END_CELL, MEM_SIZE_WORDS-2, word index of the end-address cell
HALT_CELL, MEM_SIZE_WORDS-3, word index of the halt cell

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, synchronous, active-low
bus_stb_i  in  1  data-bus strobe (snooped)
bus_we_i  in  DATA_WIDTH/8  byte write enables (snooped)
bus_addr_i  in  ADDR_WIDTH  byte address (snooped)
bus_wdata_i  in  DATA_WIDTH  write data (snooped)
bus_ack_i  in  1  slave acknowledge; a write commits when stb & |we & ack
mem_req_o  out  1  read request, single-cycle pulse
mem_addr_o  out  ADDR_WIDTH  word index to read
mem_rdata_i  in  DATA_WIDTH  read data
mem_rvalid_i  in  1  read data valid; any latency of 1 cycle or more
sig_valid_o  out  1  signature word valid
sig_data_o  out  DATA_WIDTH  signature word
sig_last_o  out  1  final word of the region
sig_ready_i  in  1  sink ready
done_o  out  1  dump complete, sticky until reset
timeout_o  out  1  dump was forced by timeout, sticky
err_o  out  1  bad region: start > end or misaligned bounds, sticky
cycle_cnt_o  out  CNT_WIDTH  cycles spent in RUN
crc_o  out  32  CRC-32 of the emitted words (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; shadow cells 0; state RUN; counter 0.
- Shadow cells: on each committed write whose masked word index equals a cell index, merge the written bytes into that shadow register lane by lane per bus_we_i.
- RUN: cycle_cnt increments every cycle.
  - Halt condition: the halt shadow equals 1, evaluated on the cycle after the merge.
  - If halt and cycle_cnt == TIMEOUT-1 occur in the same cycle, halt wins and timeout_o stays 0.
  - On reaching TIMEOUT-1 without halt: set timeout_o and still dump.
  - Either event goes to CHECK.
- CHECK (1 cycle): start and end are the shadows masked to the byte-address width.
  - Start not word-aligned, end not word-aligned, or start > end: set err_o and go to DONE; no words emitted.
  - start == end: go to DONE with zero words; sig_last_o never asserts.
  - Otherwise load ptr = start and go to READ.
- READ: pulse mem_req_o with mem_addr_o = ptr >> log2(DATA_WIDTH/8), then go to WAIT.
- WAIT: on mem_rvalid_i, register the data and go to SEND. While waiting, mem_addr_o holds its value and mem_req_o stays 0.
- SEND: hold sig_valid_o = 1 with sig_data_o and sig_last_o stable until sig_ready_i.
  - sig_last_o = (ptr + DATA_WIDTH/8 >= end).
  - On the handshake: if last, go to DONE; else ptr += DATA_WIDTH/8 and go to READ.
  - Throughput: one word per 3+ cycles.
- DONE: set done_o. Terminal state; later bus writes are ignored. Only reset leaves DONE.
- Snoop writes are ignored in every state except RUN.
- Reset mid-dump returns to RUN at the next clock with counters and shadows cleared. A half-sent word is dropped; the sink must tolerate this.

Optional Feature:
- Macro: SIG_CRC_EN.
- Defined: crc_o is a reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, final xor 0xFFFFFFFF) over the bytes of each handshaked word, LSB byte first.
  - Updates one word per handshake.
  - Holds its value in DONE; equals 0x00000000 (init xor final) when zero words are emitted.
- Undefined: crc_o is tied to 0 and no CRC logic is instantiated.

Decomposition:
- Package jedro_1_sig_pkg:
  - state enum {RUN, CHECK, READ, WAIT, SEND, DONE}
  - CRC32_POLY, CRC32_INIT, CRC32_XOROUT
  - byte-address-width and word-shift helper constants
- Sub-module jedro_1_sig_crc32: combinational next-CRC over DATA_WIDTH/8 bytes; the CRC register lives in the parent. Instantiated only under SIG_CRC_EN.

Test Plan:
- Normal dump: write start=0x100, end=0x10C, then halt=1; sink always ready; read data = index → 3 words (0x40, 0x41, 0x42), last on the 3rd word, done_o=1, timeout_o=0.
- Backpressure: same region with sig_ready_i low for 5 cycles per word → data held stable, no extra mem_req_o, all 3 words in order.
- Timeout: TIMEOUT=50, no halt write, start=0x200, end=0x204 → at cycle_cnt=49, timeout_o=1; 1 word dumped; done_o=1.
- Halt on the same cycle as the timeout boundary → timeout_o=0, dump proceeds.
- Bad region: start=0x110, end=0x100, or start=0x102 → err_o=1, done_o=1, sig_valid_o never asserts.
- Byte-lane merge: halt written as 0x00000001 via we=4'b0001 after a prior 0xFFFFFF00 write → no halt (shadow 0xFFFFFF01). Then a full write of 1 → halt.
- With SIG_CRC_EN, a single word 0x00000000 → crc_o = 0x2144DF1C.
- Reset asserted during SEND → all outputs 0 next cycle; the run restarts cleanly.
